trapezoid_feeder: RTL
=====================

Name: trapezoid_feeder

Overview:
- Initiator side of the trapezoid renderer's vertex-input protocol (`nt`/`xi`/`yi`/`busy`).
- Accepts a stream of vertices from an upstream valid/ready source and buffers them in a FIFO.
- Launches one complete 4-vertex trapezoid at a time into the renderer, only while the renderer's `busy` is low.
- Sits between the scene/command source and the trapezoid renderer; replaces the bench-driven stimulus in the integrated design.

Parameters:
- `DEPTH_TZ`, default 4: FIFO capacity in trapezoids; the FIFO holds 4*`DEPTH_TZ` vertex entries. Must be a power of 2, at least 1.
- `HOLDOFF`, default 2: cycles after the last vertex is driven during which `busy` is ignored, covering the renderer's busy-rise latency. Range 1..15.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream vertex valid.
- `in_ready`  out  1  FIFO can accept a vertex.
- `in_x`  in  8  vertex x.
- `in_y`  in  8  vertex y.
- `busy`  in  1  renderer busy.
- `nt`  out  1  new-trapezoid strobe; high only with vertex 0.
- `xi`  out  8  vertex x to renderer.
- `yi`  out  8  vertex y to renderer.
- `tz_sent`  out  16  count of trapezoids launched.
- `drop_cnt`  out  8  count of malformed trapezoids dropped (`VERTEX_CHECK_EN` only, else constant 0).

Behaviour:
- Reset values: `in_ready`=1 once reset deasserts. `nt`=0, `xi`=0, `yi`=0, `tz_sent`=0, `drop_cnt`=0. FIFO emptied; state IDLE; holdoff counter 0.
- Upstream vertex order per trapezoid: (xul,yu), (xur,yu), (xdl,yd), (xdr,yd).
- FIFO: registered array with write pointer, read pointer and occupancy count.
  - Push when `in_valid` && `in_ready`.
  - `in_ready` = !full, evaluated on current occupancy.
  - No push while full, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle: occupancy unchanged.
  - Pointers wrap modulo 4*`DEPTH_TZ`.
- All of `nt`, `xi`, `yi` are registered outputs.
- FSM states: IDLE, V0, V1, V2, V3, HOLD (plus DROP when `VERTEX_CHECK_EN` is defined).
- IDLE:
  - Launch when occupancy >= 4 && `busy`==0 && holdoff counter==0.
  - On launch: next state V0; `nt`<=1; `xi`/`yi` <= head entry; pop 1.
  - Otherwise: `nt`<=0, `xi`/`yi`<=0.
- V0 -> V1 -> V2: `nt`<=0; `xi`/`yi` <= next head entry; pop 1 each cycle.
- V2 -> V3: drives the 4th vertex and pops.
- Launch cadence: `nt` is high for exactly 1 cycle, followed by 3 consecutive vertex cycles with `nt` low. There are no gaps, and `busy` is ignored throughout V0..V3.
- V3 -> HOLD: `tz_sent`++ (wraps 16'hFFFF->0); holdoff counter loaded with `HOLDOFF`; outputs return to `nt`=0, `xi`=`yi`=0.
- HOLD: counter decrements each cycle; at 0, go to IDLE. `busy` is sampled only in IDLE.
- Latency: a 4th vertex accepted at edge t (FIFO otherwise empty, `busy` low, IDLE) gives `nt`=1 after edge t+1.
- Back-to-back: minimum launch spacing is 4 + `HOLDOFF` + 1 cycles, when `busy` stays low.
- Fewer than 4 entries buffered: stay in IDLE indefinitely; a partial trapezoid is never sent.
- `reset` asserted mid-trapezoid: immediate abort, all state returns to reset values, and buffered and partially sent vertices are discarded. The renderer is reset by the same `reset`.

Optional Feature:
- Macro: `VERTEX_CHECK_EN`.
- Defined: in IDLE, when the launch condition holds, the 4 head entries are checked combinationally. A trapezoid is well-formed when y0==y1, y2==y3, y0<=y2, x0<=x1 and x2<=x3.
  - Malformed: go to DROP for 1 cycle. Pop all 4 entries in that cycle, `drop_cnt`++ (saturating at 255), `nt` stays 0, `tz_sent` unchanged, then return to IDLE. No holdoff is applied.
  - Well-formed: launch as normal.
- Undefined: no check, no DROP state; `drop_cnt` is tied to 0 and every trapezoid is forwarded.

Test Plan:
1. Reset, push 4 vertices 1020,3020,0850,5050 (hex xxyy) with `busy`=0 -> one cycle after the 4th accept: `nt`=1 with `xi`=10 `yi`=20; then 30/20, 08/50, 50/50 with `nt`=0; `tz_sent`=1.
2. Push 2 trapezoids, hold `busy`=1 from the first V3 for 20 cycles -> second `nt` occurs exactly 1 cycle after `busy` falls, and not before `HOLDOFF` expires.
3. Fill with `DEPTH_TZ`=4 (16 vertices) and no drain (`busy`=1) -> `in_ready`=0 after the 16th accept; a 17th `in_valid` is not accepted; one launch frees 4 slots and `in_ready` returns to 1.
4. Push 3 vertices only -> `nt` never asserts over 100 cycles; the 4th vertex triggers a launch.
5. Assert `reset` during V1 -> `nt`/`xi`/`yi`=0 and `tz_sent`=0 immediately (asynchronous); FIFO is empty afterwards.
6. `VERTEX_CHECK_EN`: push 1020,3021,0850,5050 (y0≠y1) then a valid trapezoid -> `drop_cnt`=1, no `nt` for the first; the second launches normally with `tz_sent`=1.

Source files
------------

// File: rtl/trapezoid_feeder.sv
// Vertex FIFO feeding the trapezoid renderer: buffers upstream vertices and launches one
// complete 4-vertex trapezoid at a time while busy is low. Optional VERTEX_CHECK_EN drops malformed ones.
module trapezoid_feeder #(
    parameter int DEPTH_TZ = 4,
    parameter int HOLDOFF  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_x,
    input  logic [7:0]  in_y,
    input  logic        busy,
    output logic        nt,
    output logic [7:0]  xi,
    output logic [7:0]  yi,
    output logic [15:0] tz_sent,
    output logic [7:0]  drop_cnt
);

    localparam int ENTRIES = 4 * DEPTH_TZ;
    localparam int AW      = $clog2(ENTRIES);
    localparam int CW      = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(ENTRIES);
    localparam logic [CW-1:0] TZ_COUNT   = CW'(4);
    localparam logic [3:0]    HOLD_LOAD  = 4'(HOLDOFF);

`ifdef VERTEX_CHECK_EN
    typedef enum logic [2:0] {IDLE, V0, V1, V2, V3, HOLD, DROP} state_t;
`else
    typedef enum logic [2:0] {IDLE, V0, V1, V2, V3, HOLD} state_t;
`endif

    state_t state_reg, state_next;

    // Each entry packs {x, y}.
    logic [15:0]   mem [ENTRIES];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic          push;
    logic [2:0]    pop_n;
    logic [15:0]   head;

    logic          nt_reg, nt_next;
    logic [7:0]    xi_reg, xi_next;
    logic [7:0]    yi_reg, yi_next;
    logic [15:0]   tz_reg, tz_next;
    logic [3:0]    holdoff_reg, holdoff_next;
    logic          launch_ok;

    assign in_ready  = (count_reg != FULL_COUNT);
    assign push      = in_valid && in_ready;
    assign head      = mem[rd_ptr_reg];
    assign launch_ok = (count_reg >= TZ_COUNT) && !busy && (holdoff_reg == 4'd0);

    assign nt      = nt_reg;
    assign xi      = xi_reg;
    assign yi      = yi_reg;
    assign tz_sent = tz_reg;

`ifdef VERTEX_CHECK_EN
    logic [15:0] peek [4];
    logic        well_formed;
    logic [7:0]  drop_reg, drop_next;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_peek
            assign peek[gi] = mem[rd_ptr_reg + AW'(gi)];
        end
    endgenerate

    // Upper edge horizontal, lower edge horizontal and not above it, both edges left-to-right.
    assign well_formed = (peek[0][7:0] == peek[1][7:0]) &&
                         (peek[2][7:0] == peek[3][7:0]) &&
                         (peek[0][7:0] <= peek[2][7:0]) &&
                         (peek[0][15:8] <= peek[1][15:8]) &&
                         (peek[2][15:8] <= peek[3][15:8]);
    assign drop_cnt = drop_reg;
`else
    assign drop_cnt = 8'd0;
`endif

    always_comb begin
        state_next   = state_reg;
        nt_next      = 1'b0;
        xi_next      = 8'd0;
        yi_next      = 8'd0;
        pop_n        = 3'd0;
        tz_next      = tz_reg;
        holdoff_next = holdoff_reg;
`ifdef VERTEX_CHECK_EN
        drop_next    = drop_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (launch_ok) begin
`ifdef VERTEX_CHECK_EN
                    if (!well_formed) begin
                        state_next = DROP;
                    end else begin
                        state_next = V0;
                        nt_next    = 1'b1;
                        xi_next    = head[15:8];
                        yi_next    = head[7:0];
                        pop_n      = 3'd1;
                    end
`else
                    state_next = V0;
                    nt_next    = 1'b1;
                    xi_next    = head[15:8];
                    yi_next    = head[7:0];
                    pop_n      = 3'd1;
`endif
                end
            end
            V0, V1, V2: begin
                state_next = (state_reg == V0) ? V1 : (state_reg == V1) ? V2 : V3;
                xi_next    = head[15:8];
                yi_next    = head[7:0];
                pop_n      = 3'd1;
            end
            V3: begin
                state_next   = HOLD;
                tz_next      = tz_reg + 16'd1;
                holdoff_next = HOLD_LOAD;
            end
            HOLD: begin
                // Leaves on the cycle the counter reaches zero so IDLE can launch right after.
                if (holdoff_reg != 4'd0) begin
                    holdoff_next = holdoff_reg - 4'd1;
                end
                if (holdoff_reg <= 4'd1) begin
                    state_next = IDLE;
                end
            end
`ifdef VERTEX_CHECK_EN
            DROP: begin
                state_next = IDLE;
                pop_n      = 3'd4;
                if (drop_reg != 8'hFF) begin
                    drop_next = drop_reg + 8'd1;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
        count_next = count_reg + CW'(push) - CW'(pop_n);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {in_x, in_y};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            nt_reg      <= 1'b0;
            xi_reg      <= 8'd0;
            yi_reg      <= 8'd0;
            tz_reg      <= 16'd0;
            holdoff_reg <= 4'd0;
        end else begin
            state_reg   <= state_next;
            wr_ptr_reg  <= wr_ptr_reg + AW'(push);
            rd_ptr_reg  <= rd_ptr_reg + AW'(pop_n);
            count_reg   <= count_next;
            nt_reg      <= nt_next;
            xi_reg      <= xi_next;
            yi_reg      <= yi_next;
            tz_reg      <= tz_next;
            holdoff_reg <= holdoff_next;
        end
    end

`ifdef VERTEX_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_reg <= 8'd0;
        end else begin
            drop_reg <= drop_next;
        end
    end
`endif

endmodule
